// File: rtl/cube_root_unit.sv
// Sequential cube root in GF(3^97), field polynomial x^97 + x^12 + 2.
// c = a^(3^96), computed as 96 Frobenius cubes, K of them per clock.
module cube_root_unit #(
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [193:0] a,
    output logic [193:0] c,
    output logic         done
);

    localparam int ITERS = 96 / K;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((K < 1) || (K > 96) || ((96 % K) != 0)) begin : g_bad_k
        $error("cube_root_unit: K must divide 96");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [193:0]   r_w;
    logic [193:0]   r_c;
    logic [CNT_W-1:0] r_cnt;
    logic           r_done;
    logic           w_load;
    logic           w_last;
    logic [193:0]   w_chain [0:K];

    function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [1:0] gf3_neg(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    // Frobenius cube: digit i moves to degree 3i, then degrees >= 97 fold back
    // through x^97 = 2*x^12 + 1. All indices are constant, so only adds remain.
    function automatic logic [193:0] gf_cube(input logic [193:0] x);
        logic [1:0]   t [0:288];
        logic [193:0] y;
        for (int d = 0; d <= 288; d++) t[d] = 2'd0;
        for (int i = 0; i < 97; i++) t[3*i] = x[2*i +: 2];
        for (int d = 288; d >= 97; d--) begin
            t[d-97] = gf3_add(t[d-97], t[d]);
            t[d-85] = gf3_add(t[d-85], gf3_neg(t[d]));
        end
        for (int j = 0; j < 97; j++) y[2*j +: 2] = t[j];
        return y;
    endfunction

    assign w_chain[0] = r_w;
    for (genvar g = 0; g < K; g++) begin : g_cube
        assign w_chain[g+1] = gf_cube(w_chain[g]);
    end

    assign w_load = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_last = (r_state == RUN) && (r_cnt == CNT_ONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (start)  w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w    <= '0;
            r_c    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_load) begin
            r_w    <= a;
            r_cnt  <= CNT_INIT;
            r_done <= 1'b0;
        end else if (r_state == RUN) begin
            r_w   <= w_chain[K];
            r_cnt <= r_cnt - CNT_ONE;
            // c is written only here, so intermediate values never appear on it
            if (w_last) begin
                r_c    <= w_chain[K];
                r_done <= 1'b1;
            end
        end
    end

    assign c    = r_c;
    assign done = r_done;

endmodule

// File: tb/tb_cube_root_unit.sv
// Bench for cube_root_unit: K=1, 4 and 96 instances, scoreboard of operands,
// results validated by cubing them with an independent multiply-based model.
module tb_cube_root_unit;

    logic         clk;
    logic         reset;
    logic [193:0] a;
    logic         start_k [3];
    logic [193:0] c_k     [3];
    logic         done_k  [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           sel;
        logic [193:0] op;
    } sb_item_t;

    sb_item_t sb [$];

    localparam logic [193:0] ZERO  = 194'd0;
    localparam logic [193:0] ONE   = 194'd1;
    localparam logic [193:0] TWO   = 194'd2;
    localparam logic [193:0] X_POLY = 194'd4;

    cube_root_unit #(.K(1))  u_k1  (.clk(clk), .reset(reset), .start(start_k[0]), .a(a), .c(c_k[0]), .done(done_k[0]));
    cube_root_unit #(.K(4))  u_k4  (.clk(clk), .reset(reset), .start(start_k[1]), .a(a), .c(c_k[1]), .done(done_k[1]));
    cube_root_unit #(.K(96)) u_k96 (.clk(clk), .reset(reset), .start(start_k[2]), .a(a), .c(c_k[2]), .done(done_k[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [193:0] obs, input logic [193:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: full polynomial product reduced by x^97 = 2x^12 + 1.
    function automatic logic [193:0] m_mul(input logic [193:0] x, input logic [193:0] y);
        int p [0:192];
        int xd, yd, t;
        logic [193:0] r;
        for (int i = 0; i <= 192; i++) p[i] = 0;
        for (int i = 0; i < 97; i++) begin
            xd = int'(x[2*i +: 2]);
            if (xd != 0) begin
                for (int j = 0; j < 97; j++) begin
                    yd = int'(y[2*j +: 2]);
                    p[i+j] = (p[i+j] + xd * yd) % 3;
                end
            end
        end
        for (int d = 192; d >= 97; d--) begin
            t = p[d];
            p[d] = 0;
            p[d-97] = (p[d-97] + t) % 3;
            p[d-85] = (p[d-85] + 2 * t) % 3;
        end
        for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'(p[i]);
        return r;
    endfunction

    function automatic logic [193:0] m_cube(input logic [193:0] x);
        return m_mul(m_mul(x, x), x);
    endfunction

    function automatic logic [193:0] rand_elem();
        logic [193:0] r;
        for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic launch(input int sel, input logic [193:0] op);
        @(negedge clk);
        a = op;
        start_k[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_k[sel] = 1'b0;
        sb.push_back('{sel: sel, op: op});
    endtask

    task automatic wait_done(input int sel, input int budget, inout int n, output logic moved);
        logic [193:0] c0;
        int lim;
        c0 = c_k[sel];
        moved = 1'b0;
        lim = n + budget;
        while (done_k[sel] !== 1'b1 && n < lim) begin
            @(posedge clk);
            #1;
            n++;
            if (done_k[sel] !== 1'b1 && c_k[sel] !== c0) moved = 1'b1;
        end
    endtask

    task automatic pop_check(input int sel, input string tag);
        sb_item_t it;
        check({tag, "_sb_size"}, 194'(sb.size()), 194'd1);
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check({tag, "_sb_sel"}, 194'(it.sel), 194'(sel));
            check({tag, "_root"}, m_cube(c_k[sel]), it.op);
        end
    endtask

    task automatic collect(input int sel, input int lat, input string tag);
        int n;
        logic moved;
        n = 0;
        check({tag, "_done_clr"}, 194'(done_k[sel]), 194'd0);
        wait_done(sel, lat + 20, n, moved);
        check({tag, "_done"}, 194'(done_k[sel]), 194'd1);
        check({tag, "_latency"}, 194'(n), 194'(lat));
        check({tag, "_c_hold"}, 194'(moved), 194'd0);
        pop_check(sel, tag);
    endtask

    initial begin
        int n;
        logic moved;
        logic [193:0] op;

        reset = 1'b0;
        a = '0;
        for (int i = 0; i < 3; i++) start_k[i] = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_c", c_k[i], ZERO);
            check("rst_done", 194'(done_k[i]), 194'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // fixed points of the Frobenius map
        launch(0, ZERO); collect(0, 96, "k1_zero"); check("k1_zero_c", c_k[0], ZERO);
        launch(0, ONE);  collect(0, 96, "k1_one");  check("k1_one_c",  c_k[0], ONE);
        launch(0, TWO);  collect(0, 96, "k1_two");  check("k1_two_c",  c_k[0], TWO);

        launch(0, X_POLY); collect(0, 96, "k1_x");
        check("k1_x_nontrivial", 194'(c_k[0] != X_POLY), 194'd1);

        // reset mid-run: outputs clear asynchronously
        launch(0, X_POLY);
        repeat (39) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_c", c_k[0], ZERO);
        check("midrst_done", 194'(done_k[0]), 194'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        launch(0, ONE); collect(0, 96, "after_rst"); check("after_rst_c", c_k[0], ONE);

        // start pulses while running are ignored
        launch(0, ONE);
        n = 0;
        while (done_k[0] !== 1'b1 && n < 200) begin
            if (n == 9 || n == 49) begin
                start_k[0] = 1'b1;
                a = TWO;
            end else begin
                start_k[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start_k[0] = 1'b0;
        check("ign_latency", 194'(n), 194'd96);
        check("ign_c", c_k[0], ONE);
        pop_check(0, "ign");

        // back-to-back with start held high
        @(negedge clk);
        a = ONE;
        start_k[0] = 1'b1;
        @(posedge clk);
        #1;
        a = TWO;
        sb.push_back('{sel: 0, op: ONE});
        n = 0;
        wait_done(0, 120, n, moved);
        check("b2b_first_lat", 194'(n), 194'd96);
        check("b2b_first_c", c_k[0], ONE);
        pop_check(0, "b2b_first");
        @(posedge clk);
        #1;
        n++;
        sb.push_back('{sel: 0, op: TWO});
        check("b2b_gap", 194'(done_k[0]), 194'd0);
        wait_done(0, 120, n, moved);
        start_k[0] = 1'b0;
        check("b2b_period", 194'(n), 194'd193);
        check("b2b_c_hold", 194'(moved), 194'd0);
        check("b2b_second_c", c_k[0], TWO);
        pop_check(0, "b2b_second");

        for (int i = 0; i < 200; i++) begin
            op = rand_elem();
            launch(0, op);
            collect(0, 96, "k1_rand");
        end

        // wider datapaths must give the same unique cube root
        for (int i = 0; i < 20; i++) begin
            op = rand_elem();
            launch(1, op);
            collect(1, 24, "k4_rand");
            launch(2, op);
            collect(2, 1, "k96_rand");
            check("k4_vs_k96", c_k[1], c_k[2]);
        end
        launch(2, X_POLY);
        collect(2, 1, "k96_x");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
